// File: rtl/dgs_blink_decoder_pkg.sv
// dgs_blink_decoder_pkg
// Shared arithmetic for the diagnostic blink generator and decoder, plus the
// decoder FSM state type. Both sides derive their cycle counts from these
// functions so that their timing always agrees.
package dgs_blink_decoder_pkg;

   typedef enum logic [1:0] {StHunt, StIdle, StHigh, StLow} state_e;

   // Nominal pulse width (and nominal inter-pulse gap) in clock cycles.
   function automatic int unsigned pulse_cyc(input int unsigned freq_hz,
                                             input int unsigned pulse_us);
      return (freq_hz / 1000000) * pulse_us;
   endfunction

   // Accepted deviation from the nominal width, either direction.
   function automatic int unsigned tol_cyc(input int unsigned pulse);
      return pulse / 4;
   endfunction

   // Low run that ends a burst; longer than any legal inter-pulse gap.
   function automatic int unsigned gap_min_cyc(input int unsigned pulse);
      return pulse + pulse / 2;
   endfunction

   // One pulse plus one gap.
   function automatic int unsigned quant_period_cyc(input int unsigned pulse);
      return 2 * pulse;
   endfunction

   // Whole frame length; a low run this long means code 0.
   function automatic int unsigned silent_len_cyc(input int unsigned quant_cnt,
                                                  input int unsigned pulse);
      return quant_cnt * quant_period_cyc(pulse);
   endfunction

   function automatic int unsigned code_w(input int unsigned quant_cnt);
      return $clog2(quant_cnt);
   endfunction

endpackage

// File: rtl/dgs_blink_decoder_if.sv
// dgs_blink_decoder_if
// Result bus of the blink decoder.
//   CODE      last decoded pulse count, held until the next decode
//   CODE_VLD  one-cycle strobe when CODE is updated
//   ERR       one-cycle strobe on a malformed frame
// master: the decoder (drives), slave: the consumer (observes).
interface dgs_blink_decoder_if #(
   parameter int unsigned CODE_W = 3
);
   logic [CODE_W-1:0] CODE;
   logic              CODE_VLD;
   logic              ERR;

   modport master (output CODE, output CODE_VLD, output ERR);
   modport slave  (input CODE, input CODE_VLD, input ERR);
endinterface

// File: rtl/dgs_blink_decoder_sync_edge_det.sv
// dgs_blink_decoder_sync_edge_det
// Brings an asynchronous level into the CLK domain through two flops, delays
// it by one more flop and derives single-cycle rise/fall strobes.
//   CLK      clock
//   RST      synchronous active-high reset, all flops cleared to 0
//   async_i  asynchronous input level
//   level_o  synchronized level (2 cycles after async_i)
//   rise_o   high in the first cycle level_o is 1
//   fall_o   high in the first cycle level_o is 0
module dgs_blink_decoder_sync_edge_det (
   input  logic CLK,
   input  logic RST,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~dly_q;
   assign fall_o  = ~sync_q & dly_q;
endmodule

// File: rtl/dgs_blink_decoder.sv
// dgs_blink_decoder
// Measures high/low run widths on a blink line and decodes each burst of N
// short pulses into the code N; malformed bursts raise ERR instead.
//   CLK     clock
//   RST     synchronous active-high reset
//   LED_IN  blink line, asynchronous to CLK
//   bus     result bus (CODE, CODE_VLD, ERR), all registered
module dgs_blink_decoder
   import dgs_blink_decoder_pkg::*;
#(
   parameter int unsigned FREQ_HZ   = 100 * 1000 * 1000,
   parameter int unsigned PERIOD_US = 10,
   parameter int unsigned PULSE_US  = 1,
   parameter int unsigned QUANT_CNT = (PERIOD_US / PULSE_US) / 2
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                LED_IN,
   dgs_blink_decoder_if.master bus
);
   localparam int unsigned PULSE      = pulse_cyc(FREQ_HZ, PULSE_US);
   localparam int unsigned TOL        = tol_cyc(PULSE);
   localparam int unsigned GAP_MIN    = gap_min_cyc(PULSE);
   localparam int unsigned SILENT_LEN = silent_len_cyc(QUANT_CNT, PULSE);
   localparam int unsigned WCNT_W     = $clog2(SILENT_LEN + 1);
   localparam int unsigned PCNT_W     = $clog2(QUANT_CNT + 1);
   localparam int unsigned CODE_W     = code_w(QUANT_CNT);

   localparam logic [WCNT_W-1:0] W_MIN_W  = WCNT_W'(PULSE - TOL);
   localparam logic [WCNT_W-1:0] W_MAX_W  = WCNT_W'(PULSE + TOL);
   localparam logic [WCNT_W-1:0] GAP_W    = WCNT_W'(GAP_MIN);
   localparam logic [WCNT_W-1:0] SILENT_W = WCNT_W'(SILENT_LEN);
   localparam logic [WCNT_W-1:0] ONE_W    = WCNT_W'(1);
   localparam logic [PCNT_W-1:0] P_MAX    = PCNT_W'(QUANT_CNT);

   logic led_s;
   logic rise;
   logic fall;

   state_e            state_q;
   logic [WCNT_W-1:0] w_cnt_q;
   logic [PCNT_W-1:0] p_cnt_q;
   logic [CODE_W-1:0] code_q;
   logic              code_vld_q;
   logic              err_q;
   logic              w_ok;

   dgs_blink_decoder_sync_edge_det u_sync (
      .CLK     (CLK),
      .RST     (RST),
      .async_i (LED_IN),
      .level_o (led_s),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   // On an edge cycle w_cnt_q still holds the full width of the run just ended.
   assign w_ok = (w_cnt_q >= W_MIN_W) && (w_cnt_q <= W_MAX_W);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StHunt;
         w_cnt_q    <= '0;
         p_cnt_q    <= '0;
         code_q     <= '0;
         code_vld_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         code_vld_q <= 1'b0;
         err_q      <= 1'b0;

         if (rise || fall) begin
            w_cnt_q <= ONE_W;
         end else if (w_cnt_q != SILENT_W) begin
            w_cnt_q <= w_cnt_q + 1'b1;
         end

         case (state_q)
            // The fall cycle is excluded: w_cnt_q then holds a stale high width.
            StHunt: begin
               if (!led_s && !fall && (w_cnt_q >= GAP_W)) begin
                  state_q <= StIdle;
               end
            end
            StIdle: begin
               if (rise) begin
                  p_cnt_q <= '0;
                  state_q <= StHigh;
               end else if (w_cnt_q >= SILENT_W) begin
                  code_q     <= '0;
                  code_vld_q <= 1'b1;
                  w_cnt_q    <= ONE_W;
               end
            end
            StHigh: begin
               if (fall) begin
                  if (w_ok) begin
                     if (p_cnt_q != P_MAX) begin
                        p_cnt_q <= p_cnt_q + 1'b1;
                     end
                     state_q <= StLow;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= StHunt;
                  end
               end else if (w_cnt_q > W_MAX_W) begin
                  // Stuck-high line: flag it without waiting for a fall.
                  err_q   <= 1'b1;
                  state_q <= StHunt;
               end
            end
            StLow: begin
               if (rise) begin
                  if (w_ok) begin
                     state_q <= StHigh;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= StHunt;
                  end
               end else if (w_cnt_q >= GAP_W) begin
                  if (p_cnt_q < P_MAX) begin
                     code_q     <= CODE_W'(p_cnt_q);
                     code_vld_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

   assign bus.CODE     = code_q;
   assign bus.CODE_VLD = code_vld_q;
   assign bus.ERR      = err_q;
endmodule

// File: tb/tb_dgs_blink_decoder.sv
module tb_dgs_blink_decoder;
   // Timing of the default configuration, in clock cycles.
   localparam int PULSE  = 100;
   localparam int W_MIN  = 75;
   localparam int W_MAX  = 125;
   localparam int GAP    = 150;
   localparam int SILENT = 1000;
   localparam int QMAX   = 4;   // highest legal code
   localparam int LAT    = 3;   // 2 sync flops + registered output

   localparam int MODE_HUNT  = 0;
   localparam int MODE_READY = 1;
   localparam int MODE_BURST = 2;

   typedef struct {
      bit is_err;
      int code;
      int t;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic LED_IN = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   exp_t sb[$];
   bit   lvl_q[$];
   int   len_q[$];

   int   m_mode = MODE_HUNT;
   int   m_pulses = 0;
   int   m_last_code = 0;

   dgs_blink_decoder_if #(.CODE_W(3)) bus ();

   dgs_blink_decoder #(
      .FREQ_HZ   (100 * 1000 * 1000),
      .PERIOD_US (10),
      .PULSE_US  (1),
      .QUANT_CNT (5)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .LED_IN (LED_IN),
      .bus    (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input int act, input int req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s at cycle %0d: actual=%0d required=%0d", name, cyc, act, req);
      end
   endtask

   task automatic push_ev(input bit is_err, input int code, input int t);
      sb.push_back('{is_err, code, t});
      if (!is_err) m_last_code = code;
   endtask

   // Run-length reference: a run of LED_IN at 'level' lasting 'len' cycles that
   // begins right after clock edge 's'. Events land LAT cycles after the
   // LED_IN edge that decides them.
   task automatic model_run(input bit level, input int len, input int s);
      if (level) begin
         if (m_mode == MODE_READY) begin
            m_mode   = MODE_BURST;
            m_pulses = 0;
         end
         if (m_mode == MODE_BURST) begin
            if (len < W_MIN) begin
               push_ev(1'b1, m_last_code, s + len + LAT);
               m_mode = MODE_HUNT;
            end else if (len > W_MAX) begin
               push_ev(1'b1, m_last_code, s + W_MAX + 1 + LAT);
               m_mode = MODE_HUNT;
            end else begin
               m_pulses++;
            end
         end
      end else begin
         if (m_mode == MODE_BURST) begin
            if (len > GAP) begin
               if (m_pulses <= QMAX) push_ev(1'b0, m_pulses, s + GAP + LAT);
               else push_ev(1'b1, m_last_code, s + GAP + LAT);
               m_mode = MODE_READY;
            end else if (len < W_MIN || len > W_MAX) begin
               push_ev(1'b1, m_last_code, s + len + LAT);
               m_mode = MODE_HUNT;
            end
         end else if (m_mode == MODE_HUNT && len > GAP) begin
            m_mode = MODE_READY;
         end
         if (m_mode == MODE_READY) begin
            for (int k = 1; SILENT * k < len; k++) push_ev(1'b0, 0, s + LAT + SILENT * k);
         end
      end
   endtask

   task automatic drive_run(input bit level, input int len);
      model_run(level, len, cyc);
      LED_IN = level;
      repeat (len) @(posedge CLK);
      #1;
   endtask

   task automatic append(input bit level, input int len);
      if (lvl_q.size() > 0 && lvl_q[lvl_q.size() - 1] == level)
         len_q[len_q.size() - 1] += len;
      else begin
         lvl_q.push_back(level);
         len_q.push_back(len);
      end
   endtask

   // A transmitter-style frame of n pulses in a SILENT-cycle period.
   task automatic frame(input int n);
      for (int i = 0; i < n; i++) begin
         append(1'b1, PULSE);
         if (i < n - 1) append(1'b0, PULSE);
      end
      append(1'b0, (n == 0) ? SILENT : SILENT - (2 * PULSE * n - PULSE));
   endtask

   task automatic drive_list();
      while (lvl_q.size() > 0) begin
         drive_run(lvl_q.pop_front(), len_q.pop_front());
      end
   endtask

   function automatic int pick_width();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(1, 200));
      return int'($urandom_range(W_MIN, W_MAX));
   endfunction

   // Holds LED_IN low, pulses reset, then continues the low run for 'cont'.
   task automatic do_reset(input int cont);
      int r;
      LED_IN = 1'b0;
      repeat (20) @(posedge CLK);
      #1;
      RST = 1'b1;
      m_mode = MODE_HUNT;
      m_last_code = 0;
      repeat (5) begin
         @(posedge CLK);
         #1;
         chk(bus.CODE == 3'd0, "reset_code", int'(bus.CODE), 0);
         chk(bus.CODE_VLD == 1'b0, "reset_code_vld", int'(bus.CODE_VLD), 0);
         chk(bus.ERR == 1'b0, "reset_err", int'(bus.ERR), 0);
      end
      RST = 1'b0;
      r = cyc;
      // The flops were cleared to 0, so the low run counts as starting 2
      // cycles before the last reset edge.
      model_run(1'b0, cont + 2, r - 2);
      repeat (cont) @(posedge CLK);
      #1;
   endtask

   // Monitor: pops one expected event whenever the DUT strobes.
   always @(negedge CLK) begin
      if (!RST) begin
         while (sb.size() > 0 && sb[0].t < cyc) begin
            chk(sb[0].t >= cyc, "event_missing", cyc, sb[0].t);
            void'(sb.pop_front());
         end
         if (bus.CODE_VLD || bus.ERR) begin
            chk(!(bus.CODE_VLD && bus.ERR), "vld_err_exclusive", int'(bus.ERR), 0);
            chk(sb.size() != 0, "unexpected_event", int'(bus.CODE), -1);
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk(bus.ERR == e.is_err, "event_kind_err", int'(bus.ERR), int'(e.is_err));
               chk(int'(bus.CODE) == e.code, "event_code", int'(bus.CODE), e.code);
               chk(cyc == e.t, "event_cycle", cyc, e.t);
            end
         end
      end
   end

   initial begin
      do_reset(300);

      // Directed frames.
      frame(3); frame(3); frame(3);
      frame(0); frame(0);
      frame(4); frame(4);
      for (int i = 0; i < 5; i++) begin      // 5-pulse burst: over range
         append(1'b1, PULSE);
         if (i < 4) append(1'b0, PULSE);
      end
      append(1'b0, 300);
      frame(4);
      append(1'b1, 100); append(1'b0, 100); append(1'b1, 70);   // short pulse
      append(1'b0, 100); append(1'b1, 100); append(1'b0, 600);
      frame(2);
      append(1'b1, 100); append(1'b0, 100); append(1'b1, 130);  // long pulse
      append(1'b0, 100); append(1'b1, 100); append(1'b0, 600);
      frame(3);
      append(1'b1, 200); append(1'b0, 400);                     // stuck high
      frame(1);
      append(1'b1, 100); append(1'b0, 60); append(1'b1, 100);   // short gap
      append(1'b0, 600);
      frame(3);
      append(1'b1, 100); append(1'b0, 140); append(1'b1, 100);  // gap in (W_MAX, GAP)
      append(1'b0, 600);
      frame(2);

      // Randomized bursts with occasional bad widths and gaps.
      for (int f = 0; f < 16; f++) begin
         int n;
         n = int'($urandom_range(0, 6));
         for (int i = 0; i < n; i++) begin
            append(1'b1, pick_width());
            if (i < n - 1) append(1'b0, pick_width());
         end
         append(1'b0, int'($urandom_range(GAP + 1, 2200)));
      end
      append(1'b0, 300);
      drive_list();

      // Reset in the gap after the 2nd pulse of a 3-pulse frame.
      drive_run(1'b1, PULSE);
      drive_run(1'b0, PULSE);
      drive_run(1'b1, PULSE);
      do_reset(75);
      append(1'b1, PULSE);
      append(1'b0, 500);
      frame(3); frame(3);
      append(1'b0, 300);
      drive_list();

      repeat (10) @(posedge CLK);
      #1;
      chk(sb.size() == 0, "events_pending", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dgs_blink_decoder.md
# dgs_blink_decoder

Receive-side counterpart of the diagnostic blink generator. It samples a single blink line (an LED drive net or an external opto/pin input) and measures the high and low widths. It decodes each frame of N short pulses into the number N and flags malformed frames. It sits on test boards and in self-check benches that confirm which diagnostic code a unit is reporting.

## Interface
- FREQ_HZ, 100*1000*1000, clock frequency in Hz
- PERIOD_US, 10, frame period in µs (must match transmitter)
- PULSE_US, 1, nominal pulse width and nominal inter-pulse gap in µs
- QUANT_CNT, (PERIOD_US/PULSE_US)/2, quants per frame; legal codes 0..QUANT_CNT-1
- CLK  in  1  clock; single clock domain
- RST  in  1  reset; synchronous and active-high
- LED_IN  in  1  blink line; asynchronous to CLK
- CODE  out  $clog2(QUANT_CNT)  last decoded pulse count; holds until the next decode
- CODE_VLD  out  1  one-cycle strobe when CODE is updated
- ERR  out  1  one-cycle strobe on a malformed frame; CODE is left unchanged

## Operation
- Derived constants:
  - PULSE = (FREQ_HZ/1000000)*PULSE_US
  - TOL = PULSE/4
  - W_MIN = PULSE-TOL
  - W_MAX = PULSE+TOL
  - GAP_MIN = PULSE+PULSE/2
  - QUANT_PERIOD = 2*PULSE
  - SILENT_LEN = QUANT_CNT*QUANT_PERIOD
- Input path: LED_IN goes through a 2-flop synchronizer to give led_s, then a third flop to give led_d for edge detection.
- Width counter w_cnt: width $clog2(SILENT_LEN+1). It loads 1 on every led_s edge, increments otherwise, and saturates at SILENT_LEN.
- Pulse counter p_cnt: width $clog2(QUANT_CNT+1).
- FSM states: HUNT, IDLE, HIGH, LOW.
  - HUNT (after reset): discard activity until led_s has been low for GAP_MIN consecutive cycles, then go to IDLE. This prevents decoding a partial frame.
  - IDLE: line is low with no burst in progress.
    - Rising edge: p_cnt=0, go to HIGH.
    - Low run reaching SILENT_LEN: emit CODE=0. Restart w_cnt at 1, so CODE=0 repeats every SILENT_LEN cycles of continuous low.
  - HIGH: on the falling edge, check the measured high width.
    - W_MIN <= width <= W_MAX: p_cnt++, go to LOW.
    - Otherwise: ERR, go to HUNT.
    - High run exceeding W_MAX without a fall: ERR immediately, go to HUNT (stuck-high line).
  - LOW: rising edge with low width W_MIN..W_MAX goes to HIGH.
    - Rising edge with low width < W_MIN: ERR, go to HUNT.
    - Rising edge with width in (W_MAX, GAP_MIN) also gives ERR and goes to HUNT.
    - Low run reaching GAP_MIN: burst complete. If p_cnt <= QUANT_CNT-1, set CODE=p_cnt and pulse CODE_VLD; otherwise ERR. Then go to IDLE.
- p_cnt saturates at QUANT_CNT, so an over-long burst can never wrap to a legal code.
- Simultaneous events: reset has priority over every other event. A burst-complete decision and an edge cannot coincide, because completion is decided only while led_s is low.

## Timing
- Reset values: CODE=0, CODE_VLD=0, ERR=0, state=HUNT, all counters 0. Synchronizer flops reset to 0.
- Reset asserted mid-frame aborts the frame; no strobe is issued. After release, the block needs a full GAP_MIN low run before decoding.
- LED_IN to led_s latency is 2 cycles.
- CODE_VLD and CODE change together. They are registered the cycle after the low run count equals GAP_MIN, which is GAP_MIN+3 cycles after the last falling edge on LED_IN.
- ERR for a bad width is registered the cycle after the offending edge is seen on led_s.
- CODE_VLD and ERR are never asserted in the same cycle. Each is high for exactly one cycle per event.

## Structure
- Shared package holds:
  - the derived-constant functions (PULSE, TOL, GAP_MIN, SILENT_LEN)
  - the FSM state enumeration
  - so that the generator bench and the decoder use identical arithmetic.
- One natural sub-module: sync_edge_det, containing the 2-flop synchronizer, the delay flop, and rise/fall strobes. It is reusable for other asynchronous diagnostic inputs.
- The FSM and counters live in the top module, estimated at 150–250 lines.

## Test plan
All scenarios use the defaults: PULSE=100, W 75..125, GAP_MIN=150, SILENT_LEN=1000.
- Generator driven with BLINK_CNT=3, looped into LED_IN -> the first frame after reset is discarded. Thereafter CODE=3 with CODE_VLD once per 1000 cycles, 153 cycles after each third fall; ERR never asserted.
- BLINK_CNT=0 (line constantly low) -> CODE=0 strobe every 1000 cycles; no ERR.
- BLINK_CNT=4 (maximum) -> CODE=4 each frame. A hand-built 5-pulse burst -> ERR and CODE stays at 4.
- Pulse width 70 cycles, then separately 130 cycles, within a burst -> ERR one cycle after the fall; next good frame decodes correctly.
- LED_IN held high for 200 cycles -> ERR at high-run count 126, block returns to HUNT; recovers on the next valid frame.
- RST asserted after the 2nd pulse of a 3-pulse frame -> no CODE_VLD for that frame; all outputs 0 during reset; correct CODE=3 on the next full frame.
